// File: rtl/temp_sample_source.sv
// Periodic 12-bit SPI ADC sampler. Runs one 16-bit read per frame and hands
// each valid sample to the statistics block as a one-cycle enable strobe.
module temp_sample_source #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic        i_CLK,
  input  logic        i_RESET_N,
  input  logic        i_RUN,
  input  logic        i_MODE_SEL,
  input  logic        i_ADC_MISO,
  output logic        o_ADC_CS_N,
  output logic        o_ADC_SCLK,
  output logic [11:0] o_temp_NEW,
  output logic        o_ENABLE,
  output logic        o_MODE,
  output logic        o_BUSY,
  output logic        o_FRAME_ERR
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LOAD = PW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, WAIT} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [4:0]    half_cnt, half_nx;
  logic [15:0]   sreg, sreg_nx;
  logic [PW-1:0] per_cnt, per_nx;
  logic [11:0]   temp_nx;
  logic          mode_nx, en_nx, err_nx, cs_n_nx, sclk_nx, busy_nx;
  logic          start, div_last, hdr_ok;

  assign div_last = (div_cnt == DIV_LAST);
  assign hdr_ok   = (sreg[15:12] == 4'h0);

  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    half_nx  = half_cnt;
    sreg_nx  = sreg;
    per_nx   = (per_cnt == '0) ? '0 : per_cnt - PW'(1);
    temp_nx  = o_temp_NEW;
    mode_nx  = o_MODE;
    en_nx    = 1'b0;
    err_nx   = 1'b0;
    start    = 1'b0;

    case (state)
      IDLE: start = i_RUN;
      CS_SETUP: begin
        div_nx = div_cnt + DW'(1);
        if (div_last) begin
          div_nx   = '0;
          half_nx  = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        div_nx = div_cnt + DW'(1);
        if (div_last) begin
          div_nx = '0;
          // end of a low half is the SCLK rising edge: capture MISO there
          if (!half_cnt[0]) sreg_nx = {sreg[14:0], i_ADC_MISO};
          if (half_cnt == 5'd31) begin
            state_nx = CS_HOLD;
            en_nx    = hdr_ok;
            err_nx   = !hdr_ok;
            if (hdr_ok) temp_nx = sreg[11:0];
          end else begin
            half_nx = half_cnt + 5'd1;
          end
        end
      end
      CS_HOLD: begin
        div_nx = div_cnt + DW'(1);
        if (div_last) begin
          div_nx = '0;
          // short periods chain straight into the next frame, no WAIT cycle
          if (per_cnt == '0) begin
            if (i_RUN) start = 1'b1;
            else       state_nx = IDLE;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (per_cnt == '0) begin
          if (i_RUN) start = 1'b1;
          else       state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (start) begin
      state_nx = CS_SETUP;
      div_nx   = '0;
      per_nx   = PER_LOAD;
      mode_nx  = i_MODE_SEL;
    end

    cs_n_nx = !(state_nx == CS_SETUP || state_nx == SHIFT);
    busy_nx = (state_nx == CS_SETUP || state_nx == SHIFT || state_nx == CS_HOLD);
    sclk_nx = (state_nx == SHIFT) && half_nx[0];
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state       <= IDLE;
      div_cnt     <= '0;
      half_cnt    <= '0;
      sreg        <= '0;
      per_cnt     <= '0;
      o_ADC_CS_N  <= 1'b1;
      o_ADC_SCLK  <= 1'b0;
      o_temp_NEW  <= '0;
      o_ENABLE    <= 1'b0;
      o_MODE      <= 1'b0;
      o_BUSY      <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      state       <= state_nx;
      div_cnt     <= div_nx;
      half_cnt    <= half_nx;
      sreg        <= sreg_nx;
      per_cnt     <= per_nx;
      o_ADC_CS_N  <= cs_n_nx;
      o_ADC_SCLK  <= sclk_nx;
      o_temp_NEW  <= temp_nx;
      o_ENABLE    <= en_nx;
      o_MODE      <= mode_nx;
      o_BUSY      <= busy_nx;
      o_FRAME_ERR <= err_nx;
    end
  end

endmodule

// File: doc/temp_sample_source.md
TEMP_SAMPLE_SOURCE -- requirements
Module: temp_sample_source

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in i_CLK cycles (>=2).
REQ-002 Parameter SAMPLE_PERIOD, default 200: i_CLK cycles between conversion frame starts.
REQ-003 i_CLK  input  1  single clock; all logic on its rising edge.
REQ-004 i_RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 i_RUN  input  1  level; 1 = acquire samples periodically.
REQ-006 i_MODE_SEL  input  1  statistic select (0=average, 1=std dev), forwarded with each sample.
REQ-007 i_ADC_MISO  input  1  serial data from external 12-bit ADC.
REQ-008 o_ADC_CS_N  output  1  ADC chip select, active-low.
REQ-009 o_ADC_SCLK  output  1  ADC serial clock, idles low.
REQ-010 o_temp_NEW  output  12  latest valid sample, feeds statistics block sample input.
REQ-011 o_ENABLE  output  1  one-cycle strobe, o_temp_NEW/o_MODE valid, feeds statistics block enable.
REQ-012 o_MODE  output  1  i_MODE_SEL captured at frame start.
REQ-013 o_BUSY  output  1  high while a frame is in progress.
REQ-014 o_FRAME_ERR  output  1  one-cycle pulse on malformed frame.

Function
REQ-015 FSM states SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD, WAIT; all outputs registered.
REQ-016 IDLE: CS_N=1, SCLK=0; i_RUN=1 -> CS_SETUP; that cycle is frame cycle 0.
REQ-017 On frame start the period counter SHALL load SAMPLE_PERIOD-1 and decrement each cycle, saturating at 0; o_MODE <= i_MODE_SEL.
REQ-018 CS_SETUP: CS_N=0, SCLK=0 for CLK_DIV cycles, then SHIFT.
REQ-019 SHIFT: CS_N=0; SCLK toggles every CLK_DIV cycles starting low, 16 full periods (32*CLK_DIV cycles); i_ADC_MISO shifted in MSB-first on each SCLK low->high transition.
REQ-020 Frame format: 16 bits, bits[15:12] SHALL be 0, bits[11:0] = sample.
REQ-021 CS_HOLD: entered at frame cycle 33*CLK_DIV; CS_N=1, SCLK=0 for CLK_DIV cycles.
REQ-022 In the first CS_HOLD cycle with bits[15:12]==0: o_temp_NEW <= bits[11:0], o_ENABLE=1 for exactly that cycle.
REQ-023 With bits[15:12]!=0: o_FRAME_ERR=1 for that cycle, o_ENABLE stays 0, o_temp_NEW retains prior value.
REQ-024 After CS_HOLD -> WAIT; WAIT exits when period counter==0: i_RUN=1 -> CS_SETUP (new frame start), else IDLE.
REQ-025 SAMPLE_PERIOD < 34*CLK_DIV: next frame SHALL start the cycle after CS_HOLD ends (frames never overlap; spacing 34*CLK_DIV).
REQ-026 i_RUN deassert mid-frame: frame completes normally including strobe, then IDLE.
REQ-027 i_MODE_SEL changes mid-frame SHALL not affect the current frame's o_MODE.
REQ-028 o_BUSY=1 exactly in CS_SETUP, SHIFT, CS_HOLD.
REQ-029 o_ENABLE and o_FRAME_ERR SHALL never be high simultaneously; strobes spaced exactly max(SAMPLE_PERIOD, 34*CLK_DIV) cycles under continuous i_RUN.

Reset
REQ-030 i_RESET_N=0 SHALL immediately force: state IDLE, o_ADC_CS_N=1, o_ADC_SCLK=0, o_temp_NEW=0, o_ENABLE=0, o_MODE=0, o_BUSY=0, o_FRAME_ERR=0, shift register and counters 0.
REQ-031 Reset mid-frame SHALL abort the frame with no strobe; after release, a new frame starts on the first cycle with i_RUN=1.

Verification (CLK_DIV=4, SAMPLE_PERIOD=200 unless stated)
REQ-032 Reset asserted with i_RUN=1 -> all outputs at REQ-030 values, CS_N high throughout reset.
REQ-033 ADC model returns 0x0ABC, i_MODE_SEL=1 -> o_ENABLE single pulse at frame cycle 132, o_temp_NEW=12'hABC, o_MODE=1, 16 SCLK rising edges observed.
REQ-034 Continuous i_RUN, samples 0x0001,0x0FFF,0x0800 -> three strobes 200 cycles apart with those values in order.
REQ-035 ADC model returns 0x8123 after a good 0x0055 -> o_FRAME_ERR pulse, no o_ENABLE, o_temp_NEW stays 12'h055.
REQ-036 i_RUN dropped at frame cycle 50 -> strobe at cycle 132, then IDLE, CS_N remains high; SAMPLE_PERIOD=50 run -> strobes 136 cycles apart.
REQ-037 i_RESET_N pulsed low at frame cycle 70 -> CS_N=1, SCLK=0 same cycle, no strobe; next frame after release completes correctly.
